ap_fifo_to_xilly_rd: RTL and testbench
======================================

AP_FIFO_TO_XILLY_RD -- requirements
Module: ap_fifo_to_xilly_rd

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width of the stream.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, log2 of internal buffer depth (default depth 4).
REQ-003 SHALL have port ap_clk  input  1  single clock for all logic.
REQ-004 SHALL have port ap_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port out_V_V_din  input  DATA_W  ap_fifo write data from the HLS core.
REQ-006 SHALL have port out_V_V_write  input  1  ap_fifo write strobe.
REQ-007 SHALL have port out_V_V_full_n  output  1  ap_fifo not-full; 1 = the write is accepted this cycle.
REQ-008 SHALL have port user_r_rden  input  1  Xillybus read enable.
REQ-009 SHALL have port user_r_empty  output  1  Xillybus empty.
REQ-010 SHALL have port user_r_data  output  DATA_W  Xillybus read data, registered.
REQ-011 SHALL have port user_r_eof  output  1  Xillybus end-of-file.
REQ-012 SHALL have port user_r_open  input  1  host file open.
REQ-013 SHALL have port frame_len  input  16  words per frame; 0 = unbounded (present only with FRAME_EOF_EN).
REQ-014 SHALL have port ovf_err  output  1  sticky: write attempted while full_n=0.
REQ-015 SHALL have port unf_err  output  1  sticky: rden asserted while empty=1.

Function
REQ-016 SHALL contain a circular buffer of 2^DEPTH_LOG2 words, wr_ptr/rd_ptr of DEPTH_LOG2 bits wrapping modulo depth, and a count register of DEPTH_LOG2+1 bits.
REQ-017 SHALL accept a write when out_V_V_write=1 and out_V_V_full_n=1 (both sampled at the same edge), storing din at wr_ptr and incrementing wr_ptr.
REQ-018 SHALL drive out_V_V_full_n = user_r_open & (count < depth) & !frame_done, decoded from registers only (no combinational path from out_V_V_write or user_r_rden).
REQ-019 SHALL drive user_r_empty = (count == 0), decoded from registers only.
REQ-020 SHALL perform a read when user_r_rden=1 and user_r_empty=0: user_r_data <= buf[rd_ptr] on that edge, so data is valid the cycle after rden (standard, non-FWFT); user_r_data SHALL hold its value otherwise.
REQ-021 SHALL update count by +1 on write-only, -1 on read-only, and 0 on simultaneous accepted write and read, including at count==depth-1 and count==1.
REQ-022 SHALL ignore a write at full_n=0 (no pointer or count change) and set ovf_err.
REQ-023 SHALL ignore rden at empty=1 and set unf_err.
REQ-024 SHALL, while user_r_open=0, hold wr_ptr, rd_ptr, count and the frame counter at 0, force full_n=0 and eof=0, and clear ovf_err and unf_err; buffered words SHALL be discarded when open falls.
REQ-025 SHALL keep user_r_data unchanged across open/close.

Reset
REQ-026 SHALL, on ap_rst_n=0 (asynchronous), clear wr_ptr, rd_ptr, count, frame counter, frame_done, user_r_data, user_r_eof, ovf_err and unf_err to 0, giving full_n=0 and empty=1.
REQ-027 SHALL release reset synchronously to ap_clk and need no further initialization sequence.
REQ-028 SHALL return to the reset state within the same cycle if reset is asserted mid-frame, with no partial write committed.

Configuration
REQ-029 SHALL use macro AP_XILLY_FRAME_EOF_EN to compile frame/EOF support in or out.
REQ-030 SHALL, with the macro defined, implement:
- 16-bit frame counter incremented per accepted write;
- frame_len sampled into a register every cycle open=0 and frozen while open=1;
- when the counter reaches a nonzero frame_len: frame_done=1 (full_n forced 0);
- when frame_done=1 and count=0: user_r_eof=1 registered, held until open=0.
REQ-031 SHALL, without the macro, omit the frame_len port and tie user_r_eof to 0 and frame_done to 0.

Verification
REQ-032 SHALL pass: after reset, open=1, write 0xA0..0xA3 on 4 consecutive cycles, no rden -> full_n=0 after the 4th write, 5th write ignored, ovf_err=1.
REQ-033 SHALL pass: count=2, write and rden in the same cycle for 10 cycles -> count stays 2, data returns in order with 1-cycle latency, no errors.
REQ-034 SHALL pass: empty buffer, rden=1 for 1 cycle -> user_r_data unchanged, unf_err=1, count stays 0.
REQ-035 SHALL pass (macro on): frame_len=3, write 0x11,0x22,0x33, then drain -> full_n=0 after 3rd write, eof=1 one cycle after the last rden, eof=0 the cycle after open falls.
REQ-036 SHALL pass: 3 words buffered, open dropped for 1 cycle then reasserted -> empty=1, count=0, errors cleared, next write 0x55 read back as 0x55.
REQ-037 SHALL pass: ap_rst_n pulsed low mid-stream with 2 words buffered -> all outputs at reset values immediately, before the next ap_clk edge.

Source files
------------

// File: rtl/ap_fifo_to_xilly_rd.sv
// ap_fifo_to_xilly_rd: bridges an HLS ap_fifo output stream to a Xillybus
// read (FPGA-to-host) pipe through a small circular buffer.
// Optional frame/EOF support is compiled in with `define AP_XILLY_FRAME_EOF_EN;
// without it the frame_len port is absent and user_r_eof is tied low.
module ap_fifo_to_xilly_rd #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [DATA_W-1:0] out_V_V_din,
   input  logic              out_V_V_write,
   output logic              out_V_V_full_n,
   input  logic              user_r_rden,
   output logic              user_r_empty,
   output logic [DATA_W-1:0] user_r_data,
   output logic              user_r_eof,
   input  logic              user_r_open,
`ifdef AP_XILLY_FRAME_EOF_EN
   input  logic [15:0]       frame_len,
`endif
   output logic              ovf_err,
   output logic              unf_err
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_next;
   logic [DATA_W-1:0] r_data;
   logic              r_ovf;
   logic              r_unf;
   logic              w_frame_done;
   logic              w_full_n;
   logic              w_empty;
   logic              w_wr;
   logic              w_rd;

   // Flow-control decode; reset term keeps full_n low while ap_rst_n is held
   assign w_full_n = ap_rst_n & user_r_open & (r_count < CNT_W'(DEPTH)) & ~w_frame_done;
   assign w_empty  = (r_count == '0);
   assign w_wr     = out_V_V_write & w_full_n;
   assign w_rd     = user_r_rden & ~w_empty & user_r_open;

   // Occupancy after this edge: simultaneous write and read cancel out
   always_comb begin
      w_count_next = r_count;
      case ({w_wr, w_rd})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Storage array; stale words are harmless because pointers define validity
   always_ff @(posedge ap_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= out_V_V_din;
      end
   end

   // Pointers, occupancy, registered read data and sticky error flags
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_data   <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else if (!user_r_open) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_data   <= r_mem[r_rd_ptr];
         end
         r_count <= w_count_next;
         if (out_V_V_write && !w_full_n) begin
            r_ovf <= 1'b1;
         end
         if (user_r_rden && w_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

`ifdef AP_XILLY_FRAME_EOF_EN
   logic [15:0] r_frame_len;
   logic [15:0] r_frame_cnt;
   logic        r_frame_done;
   logic        r_eof;

   // Frame tracking: length latched while closed, EOF once the frame drains
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_frame_len  <= '0;
         r_frame_cnt  <= '0;
         r_frame_done <= 1'b0;
         r_eof        <= 1'b0;
      end else if (!user_r_open) begin
         r_frame_len  <= frame_len;
         r_frame_cnt  <= '0;
         r_frame_done <= 1'b0;
         r_eof        <= 1'b0;
      end else begin
         if (w_wr) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if ((r_frame_len != 16'd0) && ((r_frame_cnt + 16'd1) == r_frame_len)) begin
               r_frame_done <= 1'b1;
            end
         end
         if (r_frame_done && (w_count_next == '0)) begin
            r_eof <= 1'b1;
         end
      end
   end

   assign w_frame_done = r_frame_done;
   assign user_r_eof   = r_eof;
`else
   assign w_frame_done = 1'b0;
   assign user_r_eof   = 1'b0;
`endif

   assign out_V_V_full_n = w_full_n;
   assign user_r_empty   = w_empty;
   assign user_r_data    = r_data;
   assign ovf_err        = r_ovf;
   assign unf_err        = r_unf;

endmodule

// File: tb/tb_ap_fifo_to_xilly_rd.sv
// Self-checking bench for ap_fifo_to_xilly_rd with a queue-based scoreboard.
// Frame/EOF scenarios are compiled when AP_XILLY_FRAME_EOF_EN is defined.
module tb_ap_fifo_to_xilly_rd;

   localparam int unsigned DW = 32;

   logic          ap_clk;
   logic          ap_rst_n;
   logic [DW-1:0] out_V_V_din;
   logic          out_V_V_write;
   logic          out_V_V_full_n;
   logic          user_r_rden;
   logic          user_r_empty;
   logic [DW-1:0] user_r_data;
   logic          user_r_eof;
   logic          user_r_open;
`ifdef AP_XILLY_FRAME_EOF_EN
   logic [15:0]   frame_len;
`endif
   logic          ovf_err;
   logic          unf_err;

   int checks = 0;
   int errors = 0;

   // Scoreboard: words the model believes are buffered, plus expected flags
   logic [DW-1:0] sb[$];
   logic [DW-1:0] m_data;
   bit            m_ovf, m_unf, m_fdone, m_eof;
   int            m_fcnt, m_len;

   ap_fifo_to_xilly_rd #(.DATA_W(DW), .DEPTH_LOG2(2)) dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .out_V_V_din    (out_V_V_din),
      .out_V_V_write  (out_V_V_write),
      .out_V_V_full_n (out_V_V_full_n),
      .user_r_rden    (user_r_rden),
      .user_r_empty   (user_r_empty),
      .user_r_data    (user_r_data),
      .user_r_eof     (user_r_eof),
      .user_r_open    (user_r_open),
`ifdef AP_XILLY_FRAME_EOF_EN
      .frame_len      (frame_len),
`endif
      .ovf_err        (ovf_err),
      .unf_err        (unf_err)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   function automatic logic m_full_n();
      return ap_rst_n && user_r_open && (sb.size() < 4) && !m_fdone;
   endfunction

   function automatic logic m_empty();
      return sb.size() == 0;
   endfunction

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic model_clear();
      sb.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_fcnt  = 0;
      m_fdone = 1'b0;
      m_eof   = 1'b0;
   endtask

   // One clock of stimulus; the model is advanced from what was driven
   task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
      logic fn;
      logic was_empty;
      fn        = m_full_n();
      was_empty = m_empty();
      out_V_V_write = w;
      out_V_V_din   = d;
      user_r_rden   = r;
      step();
      out_V_V_write = 1'b0;
      user_r_rden   = 1'b0;
      if (!user_r_open) begin
         model_clear();
`ifdef AP_XILLY_FRAME_EOF_EN
         m_len = int'(frame_len);
`endif
      end else begin
         if (w && !fn) m_ovf = 1'b1;
         if (r && was_empty) m_unf = 1'b1;
         if (r && !was_empty) m_data = sb.pop_front();
         if (w && fn) begin
            sb.push_back(d);
            m_fcnt++;
            if ((m_len != 0) && (m_fcnt == m_len)) m_fdone = 1'b1;
         end
         if (m_fdone && (sb.size() == 0)) m_eof = 1'b1;
      end
   endtask

   task automatic reopen();
      user_r_open = 1'b0;
      cycle(1'b0, '0, 1'b0);
      user_r_open = 1'b1;
      cycle(1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      ap_rst_n      = 1'b0;
      user_r_open   = 1'b1;
      out_V_V_write = 1'b0;
      out_V_V_din   = '0;
      user_r_rden   = 1'b0;
`ifdef AP_XILLY_FRAME_EOF_EN
      frame_len     = 16'd0;
`endif
      model_clear();
      m_data = '0;
      m_len  = 0;
      #22;
      checks++; if (out_V_V_full_n !== 1'b0) begin errors++; $display("FAIL reset_full_n: got %b exp 0", out_V_V_full_n); end
      checks++; if (user_r_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", user_r_empty); end
      checks++; if (user_r_data !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", user_r_data); end
      checks++; if (user_r_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b exp 0", user_r_eof); end
      checks++; if ({ovf_err, unf_err} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b exp 00", {ovf_err, unf_err}); end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0);
      checks++; if (out_V_V_full_n !== 1'b1) begin errors++; $display("FAIL post_reset_full_n: got %b exp 1", out_V_V_full_n); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, DW'(32'hA0 + i), 1'b0);
         checks++; if (out_V_V_full_n !== m_full_n()) begin errors++; $display("FAIL fill_full_n[%0d]: got %b exp %b", i, out_V_V_full_n, m_full_n()); end
      end
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b exp 1", ovf_err); end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, '0, 1'b1);
         checks++; if (user_r_data !== m_data) begin errors++; $display("FAIL drain_data[%0d]: got %h exp %h", i, user_r_data, m_data); end
      end
      checks++; if (user_r_data !== 32'hA3) begin errors++; $display("FAIL drain_last: got %h exp a3", user_r_data); end
      checks++; if (unf_err !== m_unf) begin errors++; $display("FAIL drain_unf: got %b exp %b", unf_err, m_unf); end
      checks++; if (user_r_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", user_r_empty); end
   endtask

   task automatic test_back_to_back();
      reopen();
      checks++; if ({ovf_err, unf_err} !== 2'b00) begin errors++; $display("FAIL b2b_err_clear: got %b exp 00", {ovf_err, unf_err}); end
      cycle(1'b1, 32'hB0, 1'b0);
      cycle(1'b1, 32'hB1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, DW'(32'hC0 + i), 1'b1);
         checks++; if (user_r_data !== m_data) begin errors++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, user_r_data, m_data); end
         checks++; if ({out_V_V_full_n, user_r_empty, ovf_err, unf_err, user_r_eof} !== {m_full_n(), m_empty(), m_ovf, m_unf, m_eof}) begin
            errors++; $display("FAIL b2b_flags[%0d]: got %b exp %b", i, {out_V_V_full_n, user_r_empty, ovf_err, unf_err, user_r_eof}, {m_full_n(), m_empty(), m_ovf, m_unf, m_eof});
         end
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, '0, 1'b1);
         checks++; if (user_r_data !== m_data) begin errors++; $display("FAIL b2b_tail[%0d]: got %h exp %h", i, user_r_data, m_data); end
      end
      checks++; if (user_r_empty !== 1'b1) begin errors++; $display("FAIL b2b_count: got empty %b exp 1", user_r_empty); end
   endtask

   task automatic test_underflow();
      cycle(1'b0, '0, 1'b1);
      checks++; if (user_r_data !== m_data) begin errors++; $display("FAIL unf_data: got %h exp %h", user_r_data, m_data); end
      checks++; if (unf_err !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b exp 1", unf_err); end
      checks++; if (user_r_empty !== 1'b1) begin errors++; $display("FAIL unf_empty: got %b exp 1", user_r_empty); end
   endtask

   task automatic test_open_close();
      for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'hD0 + i), 1'b0);
      user_r_open = 1'b0;
      cycle(1'b0, '0, 1'b0);
      checks++; if ({out_V_V_full_n, user_r_empty, ovf_err, unf_err} !== 4'b0100) begin errors++; $display("FAIL close_flags: got %b exp 0100", {out_V_V_full_n, user_r_empty, ovf_err, unf_err}); end
      checks++; if (user_r_data !== m_data) begin errors++; $display("FAIL close_data_hold: got %h exp %h", user_r_data, m_data); end
      user_r_open = 1'b1;
      cycle(1'b0, '0, 1'b0);
      checks++; if ({out_V_V_full_n, user_r_empty} !== 2'b11) begin errors++; $display("FAIL reopen_flags: got %b exp 11", {out_V_V_full_n, user_r_empty}); end
      cycle(1'b1, 32'h55, 1'b0);
      cycle(1'b0, '0, 1'b1);
      checks++; if (user_r_data !== 32'h55) begin errors++; $display("FAIL reopen_data: got %h exp 55", user_r_data); end
      checks++; if (user_r_empty !== m_empty()) begin errors++; $display("FAIL reopen_empty: got %b exp %b", user_r_empty, m_empty()); end
   endtask

`ifdef AP_XILLY_FRAME_EOF_EN
   task automatic test_frame_eof();
      frame_len = 16'd3;
      reopen();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, DW'(32'h11 * (i + 1)), 1'b0);
         checks++; if (out_V_V_full_n !== m_full_n()) begin errors++; $display("FAIL frame_full_n[%0d]: got %b exp %b", i, out_V_V_full_n, m_full_n()); end
      end
      checks++; if (out_V_V_full_n !== 1'b0) begin errors++; $display("FAIL frame_done_full_n: got %b exp 0", out_V_V_full_n); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b1);
         checks++; if (user_r_data !== m_data) begin errors++; $display("FAIL frame_data[%0d]: got %h exp %h", i, user_r_data, m_data); end
         checks++; if (user_r_eof !== m_eof) begin errors++; $display("FAIL frame_eof[%0d]: got %b exp %b", i, user_r_eof, m_eof); end
      end
      checks++; if (user_r_eof !== 1'b1) begin errors++; $display("FAIL frame_eof_set: got %b exp 1", user_r_eof); end
      frame_len   = 16'd0;
      user_r_open = 1'b0;
      cycle(1'b0, '0, 1'b0);
      checks++; if (user_r_eof !== 1'b0) begin errors++; $display("FAIL frame_eof_clear: got %b exp 0", user_r_eof); end
      user_r_open = 1'b1;
      cycle(1'b0, '0, 1'b0);
   endtask
`endif

   task automatic test_reset_mid();
      cycle(1'b1, 32'hE0, 1'b0);
      cycle(1'b1, 32'hE1, 1'b0);
      checks++; if (user_r_empty !== 1'b0) begin errors++; $display("FAIL mid_pre_empty: got %b exp 0", user_r_empty); end
      ap_rst_n = 1'b0;
      #2;
      checks++; if ({out_V_V_full_n, user_r_empty, user_r_eof, ovf_err, unf_err} !== 5'b01000) begin
         errors++; $display("FAIL mid_reset_flags: got %b exp 01000", {out_V_V_full_n, user_r_empty, user_r_eof, ovf_err, unf_err});
      end
      checks++; if (user_r_data !== '0) begin errors++; $display("FAIL mid_reset_data: got %h exp 0", user_r_data); end
      model_clear();
      m_data = '0;
      #2;
      ap_rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0);
      checks++; if ({out_V_V_full_n, user_r_empty} !== 2'b11) begin errors++; $display("FAIL mid_release_flags: got %b exp 11", {out_V_V_full_n, user_r_empty}); end
      cycle(1'b1, 32'hF0, 1'b0);
      cycle(1'b0, '0, 1'b1);
      checks++; if (user_r_data !== m_data) begin errors++; $display("FAIL mid_after_data: got %h exp %h", user_r_data, m_data); end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_back_to_back();
      test_underflow();
      test_open_close();
`ifdef AP_XILLY_FRAME_EOF_EN
      test_frame_eof();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
